// File: rtl/mem_lsu.sv
// Load/store unit: forms rs1+imm addresses, places store data on byte lanes,
// tracks up to DEPTH outstanding memory requests in issue order, and retires
// each one with sign/zero-extended load data or a precise exception.

// Protocol checker for mem_lsu. It holds the assertions so the datapath
// module stays free of verification code.
module mem_lsu_chk #(
  parameter int CNT_W = 3,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic             mem_rsp_v_i,
  input logic [CNT_W-1:0] pend_i,
  input logic [CNT_W-1:0] count_i
);
  // A response may only land on a request that is still waiting for one.
  rsp_has_target_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rsp_v_i && (pend_i == '0)));

  // Occupancy never exceeds the tracking queue size.
  count_bound_a : assert property (@(posedge clk) disable iff (!rst_n)
    (count_i <= CNT_W'(DEPTH)));
endmodule

module mem_lsu #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_v_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [4:0]        rd_i,
  output logic              mem_req_v_o,
  input  logic              mem_req_ready_i,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_adr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_strobe_o,
  input  logic              mem_rsp_v_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic              mem_rsp_err_i,
  output logic              wb_v_o,
  input  logic              wb_ready_i,
  output logic [XLEN-1:0]   wb_data_o,
  output logic [4:0]        wb_rd_o,
  output logic              wb_store_o,
  output logic              wb_exc_o,
  output logic [1:0]        wb_cause_o
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]       rd;
    logic [1:0]       size;
    logic             uns;
    logic [OFF_W-1:0] off;
    logic             store;
    logic             done;
    logic             exc;
    logic [1:0]       cause;
    logic [XLEN-1:0]  data;
  } entry_t;

  // Alignment rule per access size; a doubleword on a 32-bit datapath is
  // not a legal access and is routed down the exception path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] low);
    logic r;
    case (size)
      2'd0:    r = 1'b0;
      2'd1:    r = low[0];
      2'd2:    r = (low[1:0] != 2'b00);
      2'd3:    r = (XLEN == 32) ? 1'b1 : (low != 3'b000);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Byte enables covering 2^size bytes starting at the lane offset.
  function automatic logic [NB-1:0] lane_strobe(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic [NB-1:0] s;
    int            nbytes;
    nbytes = 32'sd1 << size;
    for (int i = 0; i < NB; i++) begin
      s[i] = (i >= int'(off)) && (i < (int'(off) + nbytes));
    end
    return s;
  endfunction

  // Pull the addressed lane down to bit 0, mask to size, then extend.
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                   input logic [OFF_W-1:0] off,
                                                   input logic [1:0] size,
                                                   input logic uns);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] mask;
    logic            sign;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'd0:    sign = sh[7];
      2'd1:    sign = sh[15];
      2'd2:    sign = sh[31];
      default: sign = sh[XLEN-1];
    endcase
    for (int i = 0; i < XLEN; i++) begin
      mask[i] = (i < (32'sd8 << size));
    end
    return (sh & mask) | ((~uns & sign) ? ~mask : {XLEN{1'b0}});
  endfunction

  entry_t           q_q [DEPTH];
  entry_t           q_d [DEPTH];
  logic [PTR_W-1:0] alloc_q, alloc_d;
  logic [PTR_W-1:0] rsp_q, rsp_d;
  logic [PTR_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ready_en_q;

  logic [XLEN-1:0]  adr_s;
  logic [OFF_W-1:0] off_s;
  logic             mis_s;
  logic             full_s;
  logic             accept_s;
  logic             rsp_fire_s;
  logic             retire_s;

  assign adr_s      = rs1_i + imm_i;
  assign off_s      = adr_s[OFF_W-1:0];
  assign mis_s      = is_misaligned(req_size_i, adr_s[2:0]);
  assign full_s     = (count_q == CNT_W'(DEPTH));
  assign accept_s   = req_v_i && req_ready_o;
  assign rsp_fire_s = mem_rsp_v_i && (pend_q != '0);
  assign retire_s   = q_q[ret_q].done && wb_ready_i;

  assign mem_we_o     = req_store_i;
  assign mem_adr_o    = adr_s;
  assign mem_wdata_o  = rs2_i << {off_s, 3'b000};
  assign mem_strobe_o = lane_strobe(req_size_i, off_s);

  // Issue handshake: aligned ops couple issue to the memory handshake,
  // misaligned ops wait for an empty queue so their exception stays precise.
  always_comb begin
    req_ready_o = 1'b0;
    mem_req_v_o = 1'b0;
    if (!ready_en_q) begin
      req_ready_o = 1'b0;
      mem_req_v_o = 1'b0;
    end else if (mis_s) begin
      req_ready_o = (count_q == '0);
      mem_req_v_o = 1'b0;
    end else begin
      req_ready_o = !full_s && mem_req_ready_i;
      mem_req_v_o = req_v_i && !full_s;
    end
  end

  // Write-back port presents the head entry once it has completed.
  always_comb begin
    wb_v_o     = q_q[ret_q].done;
    wb_data_o  = {XLEN{1'b0}};
    wb_rd_o    = 5'd0;
    wb_store_o = 1'b0;
    wb_exc_o   = 1'b0;
    wb_cause_o = 2'b00;
    if (q_q[ret_q].done) begin
      wb_data_o  = q_q[ret_q].data;
      wb_rd_o    = (q_q[ret_q].store || q_q[ret_q].exc) ? 5'd0 : q_q[ret_q].rd;
      wb_store_o = q_q[ret_q].store;
      wb_exc_o   = q_q[ret_q].exc;
      wb_cause_o = q_q[ret_q].cause;
    end else begin
      wb_data_o  = {XLEN{1'b0}};
    end
  end

  // Queue update: retire frees the head, a response completes the oldest
  // waiting entry, an accept allocates at the tail.
  always_comb begin
    q_d     = q_q;
    alloc_d = alloc_q;
    rsp_d   = rsp_q;
    ret_d   = ret_q;
    if (retire_s) begin
      q_d[ret_q].done = 1'b0;
      ret_d           = ret_q + PTR_W'(1'b1);
    end else begin
      ret_d = ret_q;
    end
    if (rsp_fire_s) begin
      q_d[rsp_q].done  = 1'b1;
      q_d[rsp_q].exc   = mem_rsp_err_i;
      q_d[rsp_q].cause = mem_rsp_err_i ? 2'b01 : 2'b00;
      q_d[rsp_q].data  = (mem_rsp_err_i || q_q[rsp_q].store) ? {XLEN{1'b0}} :
                         load_extract(mem_rdata_i, q_q[rsp_q].off, q_q[rsp_q].size, q_q[rsp_q].uns);
      rsp_d            = rsp_q + PTR_W'(1'b1);
    end else begin
      rsp_d = rsp_q;
    end
    if (accept_s) begin
      q_d[alloc_q].rd    = rd_i;
      q_d[alloc_q].size  = req_size_i;
      q_d[alloc_q].uns   = req_unsigned_i;
      q_d[alloc_q].off   = off_s;
      q_d[alloc_q].store = req_store_i;
      q_d[alloc_q].done  = mis_s;
      q_d[alloc_q].exc   = mis_s;
      q_d[alloc_q].cause = mis_s ? 2'b10 : 2'b00;
      q_d[alloc_q].data  = {XLEN{1'b0}};
      alloc_d            = alloc_q + PTR_W'(1'b1);
      // Only taken with an empty queue, so no response moves rsp_q this cycle.
      if (mis_s) begin
        rsp_d = rsp_q + PTR_W'(1'b1);
      end else begin
        rsp_d = rsp_d;
      end
    end else begin
      alloc_d = alloc_q;
    end
    count_d = count_q + CNT_W'(accept_s) - CNT_W'(retire_s);
    pend_d  = pend_q + CNT_W'(accept_s && !mis_s) - CNT_W'(rsp_fire_s);
  end

  // State registers; reset discards the whole queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_q[i] <= '0;
      end
      alloc_q    <= '0;
      rsp_q      <= '0;
      ret_q      <= '0;
      count_q    <= '0;
      pend_q     <= '0;
      ready_en_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      alloc_q    <= alloc_d;
      rsp_q      <= rsp_d;
      ret_q      <= ret_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      ready_en_q <= 1'b1;
    end
  end

  mem_lsu_chk #(.CNT_W(CNT_W), .DEPTH(DEPTH)) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_rsp_v_i (mem_rsp_v_i),
    .pend_i      (pend_q),
    .count_i     (count_q)
  );
endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu (XLEN=32, DEPTH=4): directed scenarios
// followed by random traffic, all checked against an in-order queue model.
module tb_mem_lsu;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_v_i, req_store_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] rs1_i, rs2_i, imm_i;
  logic [4:0]  rd_i;
  logic        mem_req_ready_i, mem_rsp_v_i, mem_rsp_err_i, wb_ready_i;
  logic [31:0] mem_rdata_i;
  logic        req_ready_o, mem_req_v_o, mem_we_o, wb_v_o, wb_store_o, wb_exc_o;
  logic [31:0] mem_adr_o, mem_wdata_o, wb_data_o;
  logic [3:0]  mem_strobe_o;
  logic [4:0]  wb_rd_o;
  logic [1:0]  wb_cause_o;

  always #5 clk = ~clk;

  mem_lsu #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .rd_i(rd_i),
    .mem_req_v_o(mem_req_v_o), .mem_req_ready_i(mem_req_ready_i), .mem_we_o(mem_we_o),
    .mem_adr_o(mem_adr_o), .mem_wdata_o(mem_wdata_o), .mem_strobe_o(mem_strobe_o),
    .mem_rsp_v_i(mem_rsp_v_i), .mem_rdata_i(mem_rdata_i), .mem_rsp_err_i(mem_rsp_err_i),
    .wb_v_o(wb_v_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
    .wb_store_o(wb_store_o), .wb_exc_o(wb_exc_o), .wb_cause_o(wb_cause_o)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        store;
    logic [4:0]  rd;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic        done;
    logic        exc;
    logic [1:0]  cause;
    logic [31:0] data;
  } op_t;

  op_t ops[$];
  bit  ev_accept, ev_rsp, ev_retire;
  op_t ev_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit misal(input int size, input logic [31:0] adr);
    return (adr % (32'd1 << size)) != 32'd0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rdata, input int off, input int size, input bit uns);
    longint v, span;
    span = longint'(1) << (8 << size);
    v = longint'(rdata >> (8 * off));
    v = v % span;
    if (!uns && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic int pending();
    int n = 0;
    foreach (ops[i]) if (!ops[i].done) n++;
    return n;
  endfunction

  task automatic set_req(input bit v, input bit st, input logic [1:0] sz, input bit u,
                         input logic [31:0] a, input logic [31:0] im, input logic [31:0] d, input logic [4:0] r);
    req_v_i = v; req_store_i = st; req_size_i = sz; req_unsigned_i = u;
    rs1_i = a; imm_i = im; rs2_i = d; rd_i = r;
  endtask

  task automatic idle();
    set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic set_rsp(input bit v, input logic [31:0] d, input bit e);
    mem_rsp_v_i = v; mem_rdata_i = d; mem_rsp_err_i = e;
  endtask

  // Let inputs settle, compare every output against the model, note events.
  task automatic settle_check();
    logic [31:0] adr, w, s;
    bit          mis, exp_ready, exp_memv, exp_wbv;
    int          off;
    op_t         h;
    #1;
    adr = rs1_i + imm_i;
    off = int'(adr % 32'd4);
    mis = misal(int'(req_size_i), adr);
    exp_ready = mis ? (ops.size() == 0) : ((ops.size() < DEPTH) && mem_req_ready_i);
    exp_memv  = req_v_i && (ops.size() < DEPTH) && !mis;
    chk("req_ready", {31'd0, req_ready_o}, {31'd0, exp_ready});
    chk("mem_req_v", {31'd0, mem_req_v_o}, {31'd0, exp_memv});
    if (exp_memv) begin
      w = rs2_i << (8 * off);
      s = ((32'd1 << (32'd1 << req_size_i)) - 32'd1) << off;
      chk("mem_adr", mem_adr_o, adr);
      chk("mem_we", {31'd0, mem_we_o}, {31'd0, req_store_i});
      chk("mem_wdata", mem_wdata_o, w);
      chk("mem_strobe", {28'd0, mem_strobe_o}, s & 32'hF);
    end
    exp_wbv = 1'b0;
    if (ops.size() > 0) exp_wbv = ops[0].done;
    chk("wb_v", {31'd0, wb_v_o}, {31'd0, exp_wbv});
    if (exp_wbv) begin
      h = ops[0];
      chk("wb_data", wb_data_o, h.data);
      chk("wb_rd", {27'd0, wb_rd_o}, (h.store || h.exc) ? 32'd0 : {27'd0, h.rd});
      chk("wb_store", {31'd0, wb_store_o}, {31'd0, h.store});
      chk("wb_exc", {31'd0, wb_exc_o}, {31'd0, h.exc});
      chk("wb_cause", {30'd0, wb_cause_o}, {30'd0, h.cause});
    end
    ev_accept = req_v_i && exp_ready;
    ev_rsp    = mem_rsp_v_i;
    ev_retire = exp_wbv && wb_ready_i;
    ev_op = '{store: req_store_i, rd: rd_i, size: req_size_i, uns: req_unsigned_i,
              off: off[1:0], done: mis, exc: mis, cause: mis ? 2'b10 : 2'b00, data: 32'd0};
  endtask

  // Clock edge: apply the noted events to the model in order.
  task automatic advance();
    @(posedge clk);
    if (ev_rsp) begin
      for (int i = 0; i < ops.size(); i++) begin
        if (!ops[i].done) begin
          op_t t;
          t       = ops[i];
          t.done  = 1'b1;
          t.exc   = mem_rsp_err_i;
          t.cause = mem_rsp_err_i ? 2'b01 : 2'b00;
          t.data  = (mem_rsp_err_i || t.store) ? 32'd0 :
                    exp_load(mem_rdata_i, int'(t.off), int'(t.size), t.uns);
          ops[i]  = t;
          break;
        end
      end
    end
    if (ev_retire) void'(ops.pop_front());
    if (ev_accept) ops.push_back(ev_op);
    #1;
  endtask

  task automatic tick();
    settle_check();
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: outputs quiet even with a request pending on the inputs.
    rst_n = 1'b0;
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'd0, 5'd1);
    mem_req_ready_i = 1'b1; wb_ready_i = 1'b1;
    set_rsp(1'b0, 32'd0, 1'b0);
    #12;
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd0);
    chk("rst_mem_req_v", {31'd0, mem_req_v_o}, 32'd0);
    chk("rst_wb_v", {31'd0, wb_v_o}, 32'd0);
    chk("rst_wb_exc", {31'd0, wb_exc_o}, 32'd0);
    chk("rst_wb_cause", {30'd0, wb_cause_o}, 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd_o}, 32'd0);
    rst_n = 1'b1;
    idle();
    @(posedge clk); #1;

    // LW 0x100, response 0x8000_00F0, write-back one cycle later.
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'd0, 5'd5);
    settle_check(); chk("lw_strobe", {28'd0, mem_strobe_o}, 32'hF); advance();
    idle(); set_rsp(1'b1, 32'h8000_00F0, 1'b0);
    settle_check(); chk("lw_wb_not_yet", {31'd0, wb_v_o}, 32'd0); advance();
    set_rsp(1'b0, 32'd0, 1'b0);
    settle_check(); chk("lw_data", wb_data_o, 32'h8000_00F0); chk("lw_rd", {27'd0, wb_rd_o}, 32'd5); advance();

    // LB then LBU at 0x103 with rdata 0x8000_0000.
    set_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h100, 32'd3, 32'd0, 5'd6);
    settle_check(); chk("lb_strobe", {28'd0, mem_strobe_o}, 32'h8); advance();
    set_req(1'b1, 1'b0, 2'd0, 1'b1, 32'h100, 32'd3, 32'd0, 5'd7); set_rsp(1'b1, 32'h8000_0000, 1'b0);
    tick();
    idle();
    settle_check(); chk("lb_data", wb_data_o, 32'hFFFF_FF80); advance();
    set_rsp(1'b0, 32'd0, 1'b0);
    settle_check(); chk("lbu_data", wb_data_o, 32'h0000_0080); advance();

    // SH rs2=0x1234 at 0x102.
    set_req(1'b1, 1'b1, 2'd1, 1'b0, 32'h102, 32'd0, 32'h1234, 5'd9);
    settle_check(); chk("sh_wdata", mem_wdata_o, 32'h1234_0000); chk("sh_strobe", {28'd0, mem_strobe_o}, 32'hC); advance();
    idle(); set_rsp(1'b1, 32'hDEAD_BEEF, 1'b0); tick();
    set_rsp(1'b0, 32'd0, 1'b0);
    settle_check(); chk("sh_wb_store", {31'd0, wb_store_o}, 32'd1); chk("sh_wb_rd", {27'd0, wb_rd_o}, 32'd0);
    chk("sh_wb_exc", {31'd0, wb_exc_o}, 32'd0); advance();

    // Five loads, no responses: fifth held until a slot retires, no bypass.
    for (int k = 0; k < 4; k++) begin
      set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h200 + 32'(4 * k), 32'd0, 32'd0, 5'(k + 1));
      tick();
    end
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h210, 32'd0, 32'd0, 5'd10);
    settle_check(); chk("fifth_held", {31'd0, req_ready_o}, 32'd0); advance();
    set_rsp(1'b1, 32'h0102_0304, 1'b0); tick();
    set_rsp(1'b0, 32'd0, 1'b0);
    settle_check(); chk("full_no_bypass", {31'd0, req_ready_o}, 32'd0); advance();
    settle_check(); chk("fifth_accepted", {31'd0, req_ready_o}, 32'd1); advance();
    idle();
    for (int k = 0; k < 4; k++) begin
      set_rsp(1'b1, $urandom, 1'b0); tick();
    end
    set_rsp(1'b0, 32'd0, 1'b0); tick(); tick();

    // Misaligned LW 0x101 behind two pending loads.
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'd0, 32'd0, 5'd3); tick();
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h304, 32'd0, 32'd0, 5'd4); tick();
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd1, 32'd0, 5'd12);
    settle_check(); chk("mis_stall", {31'd0, req_ready_o}, 32'd0); chk("mis_no_memv", {31'd0, mem_req_v_o}, 32'd0); advance();
    for (int k = 0; k < 12; k++) begin
      set_rsp(pending() > 0, $urandom, 1'b0);
      settle_check(); chk("mis_no_memv", {31'd0, mem_req_v_o}, 32'd0);
      if (ev_accept) begin
        advance();
        break;
      end
      advance();
    end
    idle(); set_rsp(1'b0, 32'd0, 1'b0);
    settle_check(); chk("mis_exc", {31'd0, wb_exc_o}, 32'd1); chk("mis_cause", {30'd0, wb_cause_o}, 32'd2); advance();

    // Write-back stalled three cycles while two responses arrive, second faulting.
    wb_ready_i = 1'b0;
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'd0, 32'd0, 5'd20); tick();
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h404, 32'd0, 32'd0, 5'd21); tick();
    idle(); set_rsp(1'b1, 32'h1111_2222, 1'b0); tick();
    set_rsp(1'b1, 32'h3333_4444, 1'b1);
    settle_check(); chk("hold_v", {31'd0, wb_v_o}, 32'd1); chk("hold_rd", {27'd0, wb_rd_o}, 32'd20); advance();
    set_rsp(1'b0, 32'd0, 1'b0);
    settle_check(); chk("hold_data", wb_data_o, 32'h1111_2222); advance();
    wb_ready_i = 1'b1;
    settle_check(); chk("ret1_exc", {31'd0, wb_exc_o}, 32'd0); advance();
    settle_check(); chk("ret2_exc", {31'd0, wb_exc_o}, 32'd1); chk("ret2_cause", {30'd0, wb_cause_o}, 32'd1);
    chk("ret2_rd", {27'd0, wb_rd_o}, 32'd0); chk("ret2_data", wb_data_o, 32'd0); advance();

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [1:0]  sz;
      logic [31:0] a, im, m;
      sz = 2'($urandom_range(0, 2));
      a  = $urandom;
      im = 32'($urandom_range(0, 31)) - 32'd16;
      if ($urandom_range(0, 3) != 0) begin
        m  = (32'd1 << sz) - 32'd1;
        a  = a & ~m;
        im = im & ~m;
      end
      set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
              a, im, $urandom, 5'($urandom_range(0, 31)));
      mem_req_ready_i = ($urandom_range(0, 3) != 0);
      set_rsp((pending() > 0) && ($urandom_range(0, 1) == 1), $urandom, ($urandom_range(0, 7) == 0));
      wb_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Reset mid-operation discards the queue.
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h500, 32'd0, 32'd0, 5'd8);
    set_rsp(1'b0, 32'd0, 1'b0);
    mem_req_ready_i = 1'b1; wb_ready_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wb_v", {31'd0, wb_v_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready_o}, 32'd0);
    chk("mid_rst_memv", {31'd0, mem_req_v_o}, 32'd0);
    ops.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tick();
    idle(); set_rsp(1'b1, 32'hCAFE_F00D, 1'b0); tick();
    set_rsp(1'b0, 32'd0, 1'b0);
    settle_check(); chk("post_rst_data", wb_data_o, 32'hCAFE_F00D); advance();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
